// File: rtl/fetchflare_pref_pkg.sv
// fetchflare_pref_pkg: shared types and helpers for the prefetch request arbiter
package fetchflare_pref_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_LOCK} arb_state_e;
  localparam int MAX_REQ = 256;
  function automatic int id_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [7:0] onehot2bin(input logic [MAX_REQ-1:0] oh);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) r = oh[i] ? (r | 8'(i)) : r;
    return r;
  endfunction
endpackage

// File: rtl/fetchflare_prio_enc_pref.sv
// fetchflare_prio_enc_pref: round-robin priority pick, requesters above the pointer first
module fetchflare_prio_enc_pref #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] ptr_oh,
  output logic [WIDTH-1:0] win,
  output logic             any
);
  logic [WIDTH-1:0] thermo, hi, sel;
  // thermo covers the pointer and everything below it; those lose priority
  always_comb begin
    thermo = (ptr_oh - WIDTH'(1)) | ptr_oh;
    hi     = req & ~thermo;
    sel    = |hi ? hi : req;
    win    = sel & (~sel + WIDTH'(1));
    any    = |req;
  end
endmodule

// File: rtl/fetchflare_rr_arb_pref.sv
// fetchflare_rr_arb_pref: registered round-robin arbiter with burst lock for prefetch streams
module fetchflare_rr_arb_pref
  import fetchflare_pref_pkg::*;
#(
  parameter int NUM_REQ   = 8,
  parameter bit LOCK_EN   = 1,
  parameter int MAX_BURST = 4,
  localparam int IDW      = id_width(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] lock_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_id_o,
  output logic               gnt_valid_o,
  input  logic               gnt_ready_i,
  output logic               gnt_last_o
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
  arb_state_e         state, state_nxt;
  logic [IDW-1:0]     ptr, ptr_nxt, gnt_id_nxt, win_id;
  logic [CW-1:0]      beat_cnt, beat_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, win, ptr_oh;
  logic               last_nxt, any, acc, cont;
  assign gnt_valid_o = state != ARB_IDLE;
  assign acc         = gnt_valid_o & gnt_ready_i;
  assign cont        = acc & LOCK_EN & lock_i[gnt_id_o] & req_i[gnt_id_o] & (beat_cnt < LAST_CNT);
  assign ptr_nxt     = acc ? gnt_id_o : ptr;
  assign ptr_oh      = NUM_REQ'(1) << ptr_nxt;
  assign win_id      = IDW'(onehot2bin(MAX_REQ'(win)));
  fetchflare_prio_enc_pref #(.WIDTH(NUM_REQ)) u_enc (
    .req    (req_i),
    .ptr_oh (ptr_oh),
    .win    (win),
    .any    (any)
  );
  // next grant: flush clears, lock extends the burst, otherwise re-arbitrate on accept or idle
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt_o;
    gnt_id_nxt = gnt_id_o;
    last_nxt   = gnt_last_o;
    beat_nxt   = beat_cnt;
    if (flush_i) begin
      state_nxt  = ARB_IDLE;
      gnt_nxt    = '0;
      gnt_id_nxt = '0;
      last_nxt   = 1'b0;
      beat_nxt   = '0;
    end else if (cont) begin
      state_nxt = ARB_LOCK;
      beat_nxt  = beat_cnt + CW'(1);
      last_nxt  = (beat_cnt + CW'(1)) >= LAST_CNT;
    end else if (!gnt_valid_o || acc) begin
      state_nxt  = any ? ARB_GRANT : ARB_IDLE;
      gnt_nxt    = win;
      gnt_id_nxt = win_id;
      beat_nxt   = '0;
      last_nxt   = any & ~(LOCK_EN & lock_i[win_id] & (LAST_CNT != '0));
    end
  end
  // state, pointer, burst counter and grant outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ARB_IDLE;
      ptr        <= IDW'(NUM_REQ - 1);
      beat_cnt   <= '0;
      gnt_o      <= '0;
      gnt_id_o   <= '0;
      gnt_last_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      beat_cnt   <= beat_nxt;
      gnt_o      <= gnt_nxt;
      gnt_id_o   <= gnt_id_nxt;
      gnt_last_o <= last_nxt;
    end
  end
  a_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i) $onehot0(gnt_o));
  a_stall: assert property (@(posedge clk_i) disable iff (!rstn_i)
    gnt_valid_o && !gnt_ready_i && !flush_i |=>
      gnt_valid_o && $stable(gnt_o) && $stable(gnt_id_o) && $stable(gnt_last_o));
endmodule

// File: tb/tb_fetchflare_rr_arb_pref.sv
// tb_fetchflare_rr_arb_pref: scoreboard bench with a cycle-level round-robin reference model
module tb_fetchflare_rr_arb_pref;
  localparam int N  = 8;
  localparam int MB = 4;
  localparam bit LE = 1;
  typedef struct packed {logic v; logic [2:0] id; logic last;} exp_t;
  logic clk = 1'b0;
  logic rstn_i, flush_i, gnt_ready_i, gnt_valid_o, gnt_last_o;
  logic [N-1:0] req_i, lock_i, gnt_o;
  logic [2:0] gnt_id_o;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit m_v, m_last;
  int m_id, m_ptr, m_beats;
  fetchflare_rr_arb_pref #(.NUM_REQ(N), .LOCK_EN(LE), .MAX_BURST(MB)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .flush_i     (flush_i),
    .req_i       (req_i),
    .lock_i      (lock_i),
    .gnt_o       (gnt_o),
    .gnt_id_o    (gnt_id_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_ready_i (gnt_ready_i),
    .gnt_last_o  (gnt_last_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  // reference: winner is the first requester met walking circularly upward from the last winner
  function automatic void model(input logic [N-1:0] req, input logic [N-1:0] lock, input bit ready, input bit flush);
    bit acc, cont;
    exp_t e;
    acc = m_v && ready;
    if (acc) m_ptr = m_id;
    cont = acc && LE && lock[m_id] && req[m_id] && (m_beats < MB - 1);
    if (flush) begin
      m_v = 0;
      m_beats = 0;
    end else if (cont) begin
      m_beats++;
      m_last = !(m_beats < MB - 1);
    end else if (!m_v || acc) begin
      if (req != 0) begin
        for (int k = 1; k <= N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_id = (m_ptr + k) % N;
            break;
          end
        end
        m_beats = 0;
        m_last = !(LE && lock[m_id] && MB > 1);
        m_v = 1;
      end else begin
        m_v = 0;
        m_beats = 0;
      end
    end
    e.v = m_v;
    e.id = 3'(m_id);
    e.last = m_last;
    q.push_back(e);
  endfunction
  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lock, input bit ready, input bit flush);
    req_i = req;
    lock_i = lock;
    gnt_ready_i = ready;
    flush_i = flush;
    model(req, lock, ready, flush);
    @(negedge clk);
  endtask
  task automatic do_reset;
    rstn_i = 1'b0;
    #1;
    chk("rst_valid", gnt_valid_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_id", gnt_id_o, 0);
    chk("rst_last", gnt_last_o, 0);
    m_v = 0;
    m_last = 0;
    m_id = 0;
    m_ptr = N - 1;
    m_beats = 0;
    q.push_back('0);
    @(negedge clk);
    rstn_i = 1'b1;
  endtask
  // monitor: one expected entry per cycle, compared just after the edge
  always @(posedge clk) begin
    exp_t e;
    bit ok;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      ok = e.v ? (gnt_valid_o === 1'b1 && gnt_o === (N'(1) << e.id) && gnt_id_o === e.id && gnt_last_o === e.last)
               : (gnt_valid_o === 1'b0 && gnt_o === '0);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL scoreboard @%0t: got v=%0b gnt=%h id=%0d last=%0b expected v=%0b id=%0d last=%0b",
                 $time, gnt_valid_o, gnt_o, gnt_id_o, gnt_last_o, e.v, e.id, e.last);
      end
    end
  end
  initial begin
    req_i = '0;
    lock_i = '0;
    gnt_ready_i = 1'b0;
    flush_i = 1'b0;
    rstn_i = 1'b1;
    #1 rstn_i = 1'b0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(8'h81, 8'h00, 1, 0);
      chk("rr_pair_valid", gnt_valid_o, 1);
      chk("rr_pair_id", gnt_id_o, (i % 2) ? 7 : 0);
    end
    drive(8'h00, 8'h00, 1, 0);
    chk("idle_after_drain", gnt_valid_o, 0);
    for (int i = 0; i < 9; i++) begin
      drive(8'hFF, 8'h00, 1, 0);
      chk("wrap_id", gnt_id_o, i % 8);
    end
    drive(8'h00, 8'h00, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      drive(8'h28, 8'h08, 1, 0);
      chk("burst_id", gnt_id_o, 3);
      chk("burst_last", gnt_last_o, int'(k == 4));
    end
    drive(8'h28, 8'h08, 1, 0);
    chk("after_burst_id", gnt_id_o, 5);
    drive(8'h00, 8'h00, 1, 0);
    drive(8'h04, 8'h00, 0, 0);
    chk("stall_first_id", gnt_id_o, 2);
    for (int i = 0; i < 5; i++) begin
      drive(8'h10, 8'h00, 0, 0);
      chk("stall_gnt", gnt_o, 8'h04);
    end
    drive(8'h10, 8'h00, 1, 0);
    chk("after_stall_id", gnt_id_o, 4);
    drive(8'h00, 8'h00, 1, 0);
    drive(8'h02, 8'h02, 1, 0);
    drive(8'h02, 8'h02, 1, 0);
    chk("flush_pre_id", gnt_id_o, 1);
    chk("flush_pre_last", gnt_last_o, 0);
    drive(8'hFF, 8'h00, 1, 1);
    chk("flush_valid", gnt_valid_o, 0);
    chk("flush_gnt", gnt_o, 0);
    drive(8'hFF, 8'h00, 1, 0);
    chk("post_flush_id", gnt_id_o, 2);
    drive(8'h00, 8'h00, 1, 0);
    drive(8'h10, 8'h10, 1, 0);
    drive(8'h10, 8'h10, 1, 0);
    do_reset();
    drive(8'h80, 8'h00, 1, 0);
    chk("post_reset_id", gnt_id_o, 7);
    drive(8'h00, 8'h00, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else drive(($urandom_range(0, 3) == 0) ? 8'h00 : N'($urandom), N'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    repeat (3) drive(8'h00, 8'h00, 1, 0);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
